// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding, opcodes
// and instruction-word field positions expressed as functions of the data width.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    EXEC  = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOVE = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  // Word layout: {halt, F[1:0], Rx[1:0], Ry[1:0], Data[n-1:0]}
  function automatic int instr_width(input int n);
    return n + 7;
  endfunction

  function automatic int halt_bit(input int n);
    return n + 6;
  endfunction

  function automatic int f_lsb(input int n);
    return n + 4;
  endfunction

  function automatic int rx_lsb(input int n);
    return n + 2;
  endfunction

  function automatic int ry_lsb(input int n);
    return n;
  endfunction

endpackage

// File: rtl/instr_sequencer_ir_reg.sv
// Load-enable register with asynchronous active-low clear; used for both the
// instruction register and the program counter.
module ir_reg #(
  parameter int W = 11
) (
  input  logic         clock,
  input  logic         Resetn,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or negedge Resetn) begin
    if (!Resetn) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Issue stage for the 4-bit bus processor: fetches words from a program ROM and
// hands one instruction to the processor every five clocks until a halt word.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int AW = 4,
  parameter int N  = 4,
  parameter int IW = instr_width(N)
) (
  input  logic          clock,
  input  logic          Resetn,
  input  logic          start,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  input  logic [1:0]    proc_count,
  output logic          proc_clear,
  output logic          w,
  output logic [1:0]    F,
  output logic [1:0]    Rx,
  output logic [1:0]    Ry,
  output logic [N-1:0]  Data,
  output logic          busy,
  output logic          done,
  output logic [7:0]    retired
);

  localparam int HB     = halt_bit(N);
  localparam int F_LSB  = f_lsb(N);
  localparam int RX_LSB = rx_lsb(N);
  localparam int RY_LSB = ry_lsb(N);
  localparam logic [AW-1:0] PC_LAST = '1;

  state_t        state, state_n;
  logic [IW-1:0] ir;
  logic [AW-1:0] pc, pc_d;
  logic          ir_load, pc_load;
  logic          ir_halt;

  ir_reg #(.W(IW)) u_ir (
    .clock  (clock),
    .Resetn (Resetn),
    .load   (ir_load),
    .d      (imem_rdata),
    .q      (ir)
  );

  ir_reg #(.W(AW)) u_pc (
    .clock  (clock),
    .Resetn (Resetn),
    .load   (pc_load),
    .d      (pc_d),
    .q      (pc)
  );

  assign imem_addr = pc;
  assign ir_halt   = ir[HB];
  assign F         = ir[F_LSB+1:F_LSB];
  assign Rx        = ir[RX_LSB+1:RX_LSB];
  assign Ry        = ir[RY_LSB+1:RY_LSB];
  assign Data      = ir[N-1:0];

  always_ff @(posedge clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    ir_load = 1'b0;
    pc_load = 1'b0;
    pc_d    = pc;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          state_n = FETCH;
          pc_load = 1'b1;
          pc_d    = '0;
        end
      end
      FETCH: begin
        ir_load = 1'b1;
        state_n = ISSUE;
      end
      ISSUE: begin
        state_n = ir_halt ? HALT : EXEC;
      end
      EXEC: begin
        // The processor finishes every op by T3; the last ROM word ends the program.
        if (proc_count == 2'd3) begin
          if (pc == PC_LAST) begin
            state_n = HALT;
          end else begin
            state_n = FETCH;
            pc_load = 1'b1;
            pc_d    = pc + AW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign w          = (state == ISSUE) && !ir_halt;
  assign proc_clear = (state == IDLE) || (state == FETCH) || (state == HALT);

  always_ff @(posedge clock or negedge Resetn) begin
    if (!Resetn) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      retired <= '0;
    end else begin
      busy <= (state_n == FETCH) || (state_n == ISSUE) || (state_n == EXEC);
      done <= (state_n == HALT);
      if (state == ISSUE && !ir_halt) begin
        retired <= retired + 8'd1;
      end
    end
  end

endmodule
